// File: rtl/mul_share_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the shared 24x24 multiplier.
// The slave modport is the arbiter's view; master is the view of the surrounding environment.
interface mul_share_arbiter_if;
  logic        Req0_valid;
  logic        Req1_valid;
  logic [23:0] Req0_data1;
  logic [23:0] Req0_data2;
  logic [23:0] Req1_data1;
  logic [23:0] Req1_data2;
  logic        Req0_ack;
  logic        Req1_ack;
  logic [47:0] Req0_dataout;
  logic [47:0] Req1_dataout;
  logic [2:0]  Req0_exc;
  logic [2:0]  Req1_exc;
  logic [23:0] Multi_datain1;
  logic [23:0] Multi_datain2;
  logic        Multi_valid;
  logic [47:0] Multi_dataout;
  logic [2:0]  Multi_Exc;
  logic        Multi_ack;
  logic        Grant;
  logic        Busy;

  modport slave (
    input  Req0_valid, Req1_valid, Req0_data1, Req0_data2, Req1_data1, Req1_data2,
    input  Multi_dataout, Multi_Exc, Multi_ack,
    output Req0_ack, Req1_ack, Req0_dataout, Req1_dataout, Req0_exc, Req1_exc,
    output Multi_datain1, Multi_datain2, Multi_valid, Grant, Busy
  );

  modport master (
    output Req0_valid, Req1_valid, Req0_data1, Req0_data2, Req1_data1, Req1_data2,
    output Multi_dataout, Multi_Exc, Multi_ack,
    input  Req0_ack, Req1_ack, Req0_dataout, Req1_dataout, Req0_exc, Req1_exc,
    input  Multi_datain1, Multi_datain2, Multi_valid, Grant, Busy
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one 24x24 multiplier between two requesters, with an
// ISSUE-phase timeout that returns a zero product and the reserved exception 3'b111.
module mul_share_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                CLK,
  input  logic                RSTn,
  mul_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] EXC_TMO  = 3'b111;

  state_e      state_q;
  logic        last_q;      // requester served most recently
  logic        grant_q;
  logic        busy_q;
  logic        mvalid_q;
  logic        ack0_q;
  logic        ack1_q;
  logic [7:0]  cnt_q;
  logic [23:0] op1_q;
  logic [23:0] op2_q;
  logic [47:0] result_q;
  logic [2:0]  exc_q;

  logic        sel_d;
  logic [23:0] op1_d;
  logic [23:0] op2_d;

  // Requester 1 wins when it is the only one asking, or when both ask and 0 went last.
  always_comb begin
    sel_d = bus.Req1_valid & (~bus.Req0_valid | ~last_q);
    op1_d = sel_d ? bus.Req1_data1 : bus.Req0_data1;
    op2_d = sel_d ? bus.Req1_data2 : bus.Req0_data2;
  end

  // NOTE: all state here updates with non-blocking assignments so every branch sees
  // the pre-edge values; operand and result registers are reset too, because they
  // drive outputs that must read 0 straight out of reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      busy_q   <= 1'b0;
      mvalid_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      cnt_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
      exc_q    <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Req0_valid || bus.Req1_valid) begin
            state_q  <= ISSUE;
            grant_q  <= sel_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            cnt_q    <= '0;
            mvalid_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.Multi_ack) begin
            state_q  <= RESPOND;
            result_q <= bus.Multi_dataout;
            exc_q    <= bus.Multi_Exc;
            mvalid_q <= 1'b0;
            ack0_q   <= ~grant_q;
            ack1_q   <= grant_q;
          end else if (cnt_q == TMO_LAST) begin
            state_q  <= RESPOND;
            result_q <= '0;
            exc_q    <= EXC_TMO;
            mvalid_q <= 1'b0;
            ack0_q   <= ~grant_q;
            ack1_q   <= grant_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESPOND: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          last_q  <= grant_q;
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          mvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // Results are exposed only during the one-cycle ack pulse.
  assign bus.Req0_ack      = ack0_q;
  assign bus.Req1_ack      = ack1_q;
  assign bus.Req0_dataout  = ack0_q ? result_q : '0;
  assign bus.Req1_dataout  = ack1_q ? result_q : '0;
  assign bus.Req0_exc      = ack0_q ? exc_q : '0;
  assign bus.Req1_exc      = ack1_q ? exc_q : '0;
  assign bus.Multi_datain1 = op1_q;
  assign bus.Multi_datain2 = op2_q;
  assign bus.Multi_valid   = mvalid_q;
  assign bus.Grant         = grant_q;
  assign bus.Busy          = busy_q;

endmodule
